// File: rtl/mdio_master_param.sv
// mdio_master_param
// Clause 22 MDIO management master with configurable MDC divider and
// preamble length. Handles write and read frames. On reads it releases the
// pad during turnaround and flags a turnaround error when the PHY fails to
// pull the second TA bit low.
module mdio_master_param #(
    parameter int DIV_HALF = 1,   // clk cycles per MDC half-period (>=1)
    parameter int PRE_LEN  = 32   // preamble bits before ST (0..32)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        activado,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        busy,
    output logic        mdio_done,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        err
);

    // Phase counter covers one full bit period (2*DIV_HALF cycles).
    localparam int            PW       = $clog2(2 * DIV_HALF);
    localparam logic [PW-1:0] PH_RISE  = PW'(DIV_HALF - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV_HALF - 1);
    localparam logic [5:0]    PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        DONE
    } state_t;

    state_t         state_reg;
    logic [31:0]    frame_reg;      // frame latched at start
    logic [PW-1:0]  phase_reg;      // position inside the current bit
    logic [5:0]     bit_reg;        // bit index inside the current state
    logic [15:0]    shift_reg;      // read data being assembled
    logic           ta_err_reg;     // second TA bit sampled high on a read
    logic           op_err_reg;     // invalid OP waiting for its done pulse

    // Next bit position and the pad value that bit needs.
    state_t         step_state;
    logic [5:0]     step_bit;
    logic [31:0]    frame_src;
    logic           src_read;
    logic           frame_read;
    logic           start_valid;
    logic           drv_out;
    logic           drv_oe;

    // In IDLE the first bit is launched from t_data directly, since the
    // frame register is loaded on the same edge.
    assign frame_src   = (state_reg == IDLE) ? t_data : frame_reg;
    assign src_read    = (frame_src[29:28] == 2'b10);
    assign frame_read  = (frame_reg[29:28] == 2'b10);
    assign start_valid = (t_data[29:28] == 2'b01) || (t_data[29:28] == 2'b10);

    // Advance the (state, bit) position to the following bit of the frame.
    always_comb begin
        step_state = state_reg;
        step_bit   = bit_reg + 6'd1;
        case (state_reg)
            IDLE: begin
                step_state = (PRE_LEN == 0) ? HDR : PRE;
                step_bit   = 6'd0;
            end
            PRE: begin
                if (bit_reg == PRE_LAST) begin
                    step_state = HDR;
                    step_bit   = 6'd0;
                end
            end
            HDR: begin
                if (bit_reg == 6'd13) begin
                    step_state = TA;
                    step_bit   = 6'd0;
                end
            end
            TA: begin
                if (bit_reg == 6'd1) begin
                    step_state = DATA;
                    step_bit   = 6'd0;
                end
            end
            DATA: begin
                if (bit_reg == 6'd15) begin
                    step_state = DONE;
                    step_bit   = 6'd0;
                end
            end
            default: begin
                step_state = IDLE;
                step_bit   = 6'd0;
            end
        endcase
    end

    // Pad value for the upcoming bit; reads release the pad from TA onward.
    always_comb begin
        drv_out = 1'b0;
        drv_oe  = 1'b0;
        case (step_state)
            PRE: begin
                drv_out = 1'b1;
                drv_oe  = 1'b1;
            end
            HDR: begin
                drv_out = frame_src[5'd31 - step_bit[4:0]];
                drv_oe  = 1'b1;
            end
            TA: begin
                if (!src_read) begin
                    drv_out = frame_src[5'd17 - step_bit[4:0]];
                    drv_oe  = 1'b1;
                end
            end
            DATA: begin
                if (!src_read) begin
                    drv_out = frame_src[5'd15 - step_bit[4:0]];
                    drv_oe  = 1'b1;
                end
            end
            default: begin
                drv_out = 1'b0;
                drv_oe  = 1'b0;
            end
        endcase
    end

    // Frame sequencer with registered pad, clock and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            frame_reg  <= 32'h0;
            phase_reg  <= '0;
            bit_reg    <= 6'd0;
            shift_reg  <= 16'h0;
            ta_err_reg <= 1'b0;
            op_err_reg <= 1'b0;
            mdc        <= 1'b0;
            mdio_out   <= 1'b0;
            mdio_oe    <= 1'b0;
            busy       <= 1'b0;
            mdio_done  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 16'h0;
            err        <= 1'b0;
        end else if (!activado) begin
            // Disabling abandons the frame silently; rd_data is kept.
            state_reg  <= IDLE;
            phase_reg  <= '0;
            bit_reg    <= 6'd0;
            op_err_reg <= 1'b0;
            mdc        <= 1'b0;
            mdio_out   <= 1'b0;
            mdio_oe    <= 1'b0;
            busy       <= 1'b0;
            mdio_done  <= 1'b0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mdio_done <= 1'b0;
                    rd_valid  <= 1'b0;
                    err       <= 1'b0;
                    if (mdio_start) begin
                        frame_reg  <= t_data;
                        busy       <= 1'b1;
                        phase_reg  <= '0;
                        shift_reg  <= 16'h0;
                        ta_err_reg <= 1'b0;
                        mdc        <= 1'b0;
                        if (start_valid) begin
                            state_reg <= step_state;
                            bit_reg   <= step_bit;
                            mdio_out  <= drv_out;
                            mdio_oe   <= drv_oe;
                        end else begin
                            // Bad OP: no bus activity, just report it.
                            state_reg  <= DONE;
                            op_err_reg <= 1'b1;
                        end
                    end
                end
                PRE, HDR, TA, DATA: begin
                    if (phase_reg == PH_RISE) begin
                        mdc <= 1'b1;
                        if (state_reg == TA && bit_reg == 6'd1 && frame_read && mdio_in)
                            ta_err_reg <= 1'b1;
                        if (state_reg == DATA && frame_read)
                            shift_reg <= {shift_reg[14:0], mdio_in};
                    end
                    if (phase_reg == PH_LAST) begin
                        phase_reg <= '0;
                        mdc       <= 1'b0;
                        if (step_state == DONE) begin
                            state_reg <= DONE;
                            bit_reg   <= 6'd0;
                            mdio_out  <= 1'b0;
                            mdio_oe   <= 1'b0;
                            busy      <= 1'b0;
                            mdio_done <= 1'b1;
                            if (frame_read) begin
                                if (ta_err_reg) begin
                                    err <= 1'b1;
                                end else begin
                                    rd_valid <= 1'b1;
                                    rd_data  <= shift_reg;
                                end
                            end
                        end else begin
                            state_reg <= step_state;
                            bit_reg   <= step_bit;
                            mdio_out  <= drv_out;
                            mdio_oe   <= drv_oe;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                DONE: begin
                    mdc      <= 1'b0;
                    mdio_out <= 1'b0;
                    mdio_oe  <= 1'b0;
                    if (op_err_reg) begin
                        // Invalid OP: the done/err pulse follows one cycle later.
                        op_err_reg <= 1'b0;
                        busy       <= 1'b0;
                        mdio_done  <= 1'b1;
                        err        <= 1'b1;
                    end else begin
                        mdio_done <= 1'b0;
                        rd_valid  <= 1'b0;
                        err       <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master_param.sv
// Testbench for mdio_master_param: a default instance plus a DIV_HALF=4,
// PRE_LEN=0 instance. Stimulus pushes the expected done result and the
// expected bit stream into queues; monitors pop and compare them.
module tb_mdio_master_param;

    logic        clk = 1'b0;
    logic        reset, activado, mdio_start, mdio_start2;
    logic        mdio_in = 1'b1;
    logic        mdio_in2 = 1'b1;
    logic [31:0] t_data, t_data2;

    logic        mdc, mdio_out, mdio_oe, busy, mdio_done, rd_valid, err;
    logic [15:0] rd_data;
    logic        mdc2, mdio_out2, mdio_oe2, busy2, mdio_done2, rd_valid2, err2;
    logic [15:0] rd_data2;

    mdio_master_param dut (
        .clk(clk), .reset(reset), .activado(activado), .mdio_start(mdio_start),
        .t_data(t_data), .mdio_in(mdio_in), .mdc(mdc), .mdio_out(mdio_out),
        .mdio_oe(mdio_oe), .busy(busy), .mdio_done(mdio_done),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );

    mdio_master_param #(.DIV_HALF(4), .PRE_LEN(0)) dut2 (
        .clk(clk), .reset(reset), .activado(activado), .mdio_start(mdio_start2),
        .t_data(t_data2), .mdio_in(mdio_in2), .mdc(mdc2), .mdio_out(mdio_out2),
        .mdio_oe(mdio_oe2), .busy(busy2), .mdio_done(mdio_done2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .err(err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic        rv;
        logic [15:0] rd;
    } exp_t;

    typedef struct packed {
        logic out;
        logic oe;
    } bit_t;

    exp_t q_exp[$];
    exp_t q_exp2[$];
    bit_t q_bits[$];
    bit_t q_bits2[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          rise_total = 0;
    bit          bits_en = 1'b1;
    bit          phy_en = 1'b0;
    logic [15:0] model_rd = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // PHY answer for frame bit b (1-based): TA1 released, TA2 low, then A5C3.
    function automatic logic phy_val(input int b);
        logic [15:0] d;
        d = 16'hA5C3;
        if (b == 48) return 1'b0;
        if (b >= 49 && b <= 64) return d[64 - b];
        return 1'b1;
    endfunction

    // Monitor for the default instance: done results and per-bit pad values.
    logic prev_mdc_mon = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        bit_t b;
        if (mdio_done) begin
            if (q_exp.size() == 0) begin
                flag("unexpected_done");
            end else begin
                e = q_exp.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("err", {31'b0, err}, {31'b0, e.err});
                check("rd_valid", {31'b0, rd_valid}, {31'b0, e.rv});
                check("rd_data", {16'b0, rd_data}, {16'b0, e.rd});
            end
        end else if (err || rd_valid) begin
            flag("stray_pulse");
        end
        if (mdc && !prev_mdc_mon) begin
            rise_total++;
            if (bits_en) begin
                if (q_bits.size() == 0) begin
                    flag("unexpected_mdc_bit");
                end else begin
                    b = q_bits.pop_front();
                    check("bit_oe", {31'b0, mdio_oe}, {31'b0, b.oe});
                    if (b.oe) check("bit_out", {31'b0, mdio_out}, {31'b0, b.out});
                end
            end
        end
        prev_mdc_mon = mdc;
    end

    // Monitor for the DIV_HALF=4 instance, including the MDC period.
    logic prev_mdc_mon2 = 1'b0;
    int   last_rise2 = -1;
    always @(negedge clk) begin
        exp_t e;
        bit_t b;
        if (mdio_done2) begin
            if (q_exp2.size() == 0) begin
                flag("unexpected_done2");
            end else begin
                e = q_exp2.pop_front();
                check("done_cycle2", cyc, e.cyc);
                check("err2", {31'b0, err2}, {31'b0, e.err});
                check("rd_valid2", {31'b0, rd_valid2}, {31'b0, e.rv});
            end
        end
        if (!busy2) last_rise2 = -1;
        if (mdc2 && !prev_mdc_mon2) begin
            if (last_rise2 >= 0) check("mdc_period2", cyc - last_rise2, 8);
            last_rise2 = cyc;
            if (q_bits2.size() == 0) begin
                flag("unexpected_mdc_bit2");
            end else begin
                b = q_bits2.pop_front();
                check("bit_oe2", {31'b0, mdio_oe2}, {31'b0, b.oe});
                check("bit_out2", {31'b0, mdio_out2}, {31'b0, b.out});
            end
        end
        prev_mdc_mon2 = mdc2;
    end

    // PHY model: presents each bit right after the previous rising MDC.
    logic prev_mdc_phy = 1'b0;
    int   rcnt = 0;
    always @(negedge clk) begin
        if (!busy) begin
            rcnt = 0;
            mdio_in = 1'b1;
        end else if (mdc && !prev_mdc_phy) begin
            rcnt++;
            mdio_in = phy_en ? phy_val(rcnt + 1) : 1'b1;
        end
        prev_mdc_phy = mdc;
    end

    task automatic push_bits(input logic [31:0] td, input bit is_read, input int npre, input bit sel);
        bit_t b;
        for (int i = 0; i < npre + 32; i++) begin
            if (i < npre) b = '{out: 1'b1, oe: 1'b1};
            else if (i < npre + 14 || !is_read) b = '{out: td[31 - (i - npre)], oe: 1'b1};
            else b = '{out: 1'b0, oe: 1'b0};
            if (sel) q_bits2.push_back(b);
            else q_bits.push_back(b);
        end
    endtask

    task automatic issue(input logic [31:0] td, input bit push, input bit e_err,
                         input bit e_rv, input logic [15:0] e_rd, input int lat);
        exp_t e;
        @(negedge clk);
        t_data = td;
        mdio_start = 1'b1;
        if (push) begin
            e = '{cyc: 32'(cyc + lat), err: e_err, rv: e_rv, rd: e_rd};
            q_exp.push_back(e);
        end
        @(negedge clk);
        mdio_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!mdio_done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!mdio_done) flag(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mdc"}, {31'b0, mdc}, 0);
        check({tag, "_mdio_out"}, {31'b0, mdio_out}, 0);
        check({tag, "_mdio_oe"}, {31'b0, mdio_oe}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_mdio_done"}, {31'b0, mdio_done}, 0);
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, 0);
        check({tag, "_err"}, {31'b0, err}, 0);
        check({tag, "_rd_data"}, {16'b0, rd_data}, 0);
    endtask

    initial begin
        int r0;
        exp_t e;
        int n;
        reset = 1'b1;
        activado = 1'b1;
        mdio_start = 1'b0;
        mdio_start2 = 1'b0;
        t_data = 32'h0;
        t_data2 = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Write frame with defaults.
        push_bits(32'h508ABEEF, 1'b0, 32, 1'b0);
        issue(32'h508ABEEF, 1'b1, 1'b0, 1'b0, model_rd, 129);
        wait_done("timeout_write");

        // Back-to-back read with a responding PHY.
        phy_en = 1'b1;
        push_bits(32'h636E746E, 1'b1, 32, 1'b0);
        issue(32'h636E746E, 1'b1, 1'b0, 1'b1, 16'hA5C3, 129);
        model_rd = 16'hA5C3;
        wait_done("timeout_read");

        // Read with no PHY: turnaround error, rd_data kept.
        phy_en = 1'b0;
        push_bits(32'h636E746E, 1'b1, 32, 1'b0);
        issue(32'h636E746E, 1'b1, 1'b1, 1'b0, model_rd, 129);
        wait_done("timeout_read_nophy");

        // Invalid OP: no MDC activity, done+err two cycles after start.
        r0 = rise_total;
        issue(32'h4000_0000, 1'b1, 1'b1, 1'b0, model_rd, 2);
        wait_done("timeout_invalid");
        check("invalid_no_mdc", rise_total - r0, 0);

        // Extra start and t_data change mid-write are ignored.
        push_bits(32'h508ABEEF, 1'b0, 32, 1'b0);
        issue(32'h508ABEEF, 1'b1, 1'b0, 1'b0, model_rd, 129);
        repeat (39) @(negedge clk);
        mdio_start = 1'b1;
        t_data = 32'h6FFF_0000;
        @(negedge clk);
        mdio_start = 1'b0;
        wait_done("timeout_write_restart");

        // activado dropped at cycle 60 of a write.
        bits_en = 1'b0;
        issue(32'h508ABEEF, 1'b0, 1'b0, 1'b0, model_rd, 0);
        repeat (59) @(negedge clk);
        activado = 1'b0;
        @(negedge clk);
        check("abort_mdc", {31'b0, mdc}, 0);
        check("abort_oe", {31'b0, mdio_oe}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        activado = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_rd_data", {16'b0, rd_data}, {16'b0, model_rd});
        check("abort_idle_busy", {31'b0, busy}, 0);

        // Asynchronous reset in the middle of a read.
        phy_en = 1'b1;
        issue(32'h636E746E, 1'b0, 1'b0, 1'b0, model_rd, 0);
        repeat (69) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_rd = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        bits_en = 1'b1;
        @(negedge clk);

        // Recovery read after reset.
        push_bits(32'h636E746E, 1'b1, 32, 1'b0);
        issue(32'h636E746E, 1'b1, 1'b0, 1'b1, 16'hA5C3, 129);
        model_rd = 16'hA5C3;
        wait_done("timeout_read_after_reset");

        // DIV_HALF=4, PRE_LEN=0 write.
        push_bits(32'h508ABEEF, 1'b0, 0, 1'b1);
        @(negedge clk);
        t_data2 = 32'h508ABEEF;
        mdio_start2 = 1'b1;
        e = '{cyc: 32'(cyc + 257), err: 1'b0, rv: 1'b0, rd: 16'h0};
        q_exp2.push_back(e);
        @(negedge clk);
        mdio_start2 = 1'b0;
        n = 0;
        while (!mdio_done2 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!mdio_done2) flag("timeout_div4");

        repeat (5) @(negedge clk);
        check("pending_done", q_exp.size(), 0);
        check("pending_bits", q_bits.size(), 0);
        check("pending_done2", q_exp2.size(), 0);
        check("pending_bits2", q_bits2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
